mem_access_controller: RTL and testbench

Initiator side of the data-memory interface. It accepts 16-bit or 32-bit load/store requests from the memory pipeline stage and sequences one or two 16-bit accesses on the data memory's DataIn/Address/MemoryRead/MemoryWrite/DataOut port. For reads, it assembles the returned words and hands a registered 32-bit result back to the pipeline. It sits between the MEM stage (stack pushes/pops of the 32-bit PC, LDD/STD, PUSH/POP) and data_memory, and raises a stall while an access is in flight.

---
 rtl/mem_access_controller.sv | 112 +++++++++++
 tb/tb_mem_access_controller.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_controller.sv
// Data-memory initiator: turns one 16/32-bit load/store request into one or two
// 16-bit memory accesses and returns a registered 32-bit load result.
`timescale 1ns/1ps
module mem_access_controller #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic                    req_double,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic                    resp_valid,
  output logic [2*DATA_WIDTH-1:0] resp_rdata,
  output logic                    stall,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH-1:0]   mem_data_in,
  output logic                    mem_read,
  output logic                    mem_write,
  input  logic [DATA_WIDTH-1:0]   mem_data_out
);

  typedef enum logic [1:0] {IDLE, FIRST, SECOND, DONE} state_e;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_e                    state_q, state_d;
  logic                      write_q, write_d;
  logic                      double_q, double_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [2*DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [2*DATA_WIDTH-1:0]   rdata_q, rdata_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      double_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      double_q <= double_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  // Outputs depend only on registered state and latched request fields.
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    double_d    = double_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem_address = '0;
    mem_data_in = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          write_d  = req_write;
          double_d = req_double;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          state_d  = FIRST;
        end
      end
      FIRST: begin
        mem_address = addr_q;
        mem_data_in = double_q ? wdata_q[2*DATA_WIDTH-1:DATA_WIDTH]
                               : wdata_q[DATA_WIDTH-1:0];
        mem_write   = write_q;
        mem_read    = ~write_q;
        // High half lives at the base address for double accesses.
        if (!write_q) begin
          if (double_q) rdata_d[2*DATA_WIDTH-1:DATA_WIDTH] = mem_data_out;
          else          rdata_d = {{DATA_WIDTH{1'b0}}, mem_data_out};
        end
        state_d = double_q ? SECOND : DONE;
      end
      SECOND: begin
        mem_address = addr_q + ADDR_ONE;
        mem_data_in = wdata_q[DATA_WIDTH-1:0];
        mem_write   = write_q;
        mem_read    = ~write_q;
        if (!write_q) rdata_d[DATA_WIDTH-1:0] = mem_data_out;
        state_d = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall      = ~req_ready;
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_controller.sv
// Directed bench for mem_access_controller with a small behavioural data memory.
`timescale 1ns/1ps
module tb_mem_access_controller;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, req_double = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, stall, mem_read, mem_write;
  logic [31:0] resp_rdata, mem_address;
  logic [15:0] mem_data_in, mem_data_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_controller dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_double(req_double), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .stall(stall),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_read(mem_read), .mem_write(mem_write), .mem_data_out(mem_data_out)
  );

  // 4K-word memory: low 12 address bits keep 0x7FF, 0xFFFFFFFF and 0x0 distinct.
  logic [15:0] mem [0:4095];
  always @(posedge clk) if (mem_write) mem[mem_address[11:0]] <= mem_data_in;
  assign mem_data_out = mem_read ? mem[mem_address[11:0]] : 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic        dbl;
    logic [31:0] addr;
    logic [31:0] addr2;
    logic [31:0] wdata;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt [10];

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    chk("idle_ready", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = v.wr; req_double = v.dbl;
    req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk);
    @(negedge clk);
    // scramble inputs: the block must use the latched copies
    req_valid = 1'b0; req_write = ~v.wr; req_double = ~v.dbl;
    req_addr = 32'hDEAD_BEEF; req_wdata = ~v.wdata;
    chk("first_addr", mem_address, v.addr);
    chk("first_wr", {31'b0, mem_write}, {31'b0, v.wr});
    chk("first_rd", {31'b0, mem_read}, {31'b0, ~v.wr});
    chk("first_stall", {31'b0, stall}, 32'd1);
    if (v.wr) chk("first_din", {16'b0, mem_data_in}, {16'b0, v.d0});
    if (v.dbl) begin
      @(negedge clk);
      chk("second_addr", mem_address, v.addr2);
      chk("second_wr", {31'b0, mem_write}, {31'b0, v.wr});
      if (v.wr) chk("second_din", {16'b0, mem_data_in}, {16'b0, v.d1});
    end
    @(negedge clk);
    chk("done_resp", {31'b0, resp_valid}, 32'd1);
    chk("done_rdata", resp_rdata, v.rdata);
    chk("done_memctl", {30'b0, mem_read, mem_write}, 32'd0);
    chk("done_ready", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    chk("after_resp", {31'b0, resp_valid}, 32'd0);
    chk("after_ready", {31'b0, req_ready}, 32'd1);
    chk("held_rdata", resp_rdata, v.rdata);
    if (v.wr) begin
      chk("mem_word0", {16'b0, mem[v.addr[11:0]]}, {16'b0, v.d0});
      if (v.dbl) chk("mem_word1", {16'b0, mem[v.addr2[11:0]]}, {16'b0, v.d1});
    end
  endtask

  initial begin
    int pulses;
    int first_c;
    int gap;
    //          wr    dbl   addr          addr2         wdata         d0       d1       rdata
    vt[0] = '{1'b1, 1'b0, 32'h0000_0001, 32'h0000_0002, 32'h1234_FFFF, 16'hFFFF, 16'h0000, 32'h0000_0000};
    vt[1] = '{1'b0, 1'b0, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 16'h0000, 16'h0000, 32'h0000_FFFF};
    vt[2] = '{1'b1, 1'b1, 32'h0000_0008, 32'h0000_0009, 32'h0DDF_EB5A, 16'h0DDF, 16'hEB5A, 32'h0000_FFFF};
    vt[3] = '{1'b0, 1'b1, 32'h0000_0008, 32'h0000_0009, 32'h0000_0000, 16'h0000, 16'h0000, 32'h0DDF_EB5A};
    vt[4] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 32'hCAFE_BABE, 16'hCAFE, 16'hBABE, 32'h0DDF_EB5A};
    vt[5] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 16'h0000, 16'h0000, 32'hCAFE_BABE};
    vt[6] = '{1'b0, 1'b0, 32'h0000_0008, 32'h0000_0009, 32'h0000_0000, 16'h0000, 16'h0000, 32'h0000_0DDF};
    vt[7] = '{1'b1, 1'b0, 32'h0000_07FF, 32'h0000_0800, 32'h5555_A5A5, 16'hA5A5, 16'h0000, 32'h0000_0DDF};
    vt[8] = '{1'b0, 1'b0, 32'h0000_07FF, 32'h0000_0800, 32'h0000_0000, 16'h0000, 16'h0000, 32'h0000_A5A5};
    vt[9] = '{1'b1, 1'b0, 32'h0000_0021, 32'h0000_0022, 32'h0000_BEEF, 16'hBEEF, 16'h0000, 32'h0000_A5A5};

    #12 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_resp", {31'b0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_memctl", {30'b0, mem_read, mem_write}, 32'd0);
    chk("rst_addr", mem_address, 32'd0);

    for (int i = 0; i < 10; i++) run_vec(vt[i]);

    // Back-to-back single loads with req_valid held and address changing while busy.
    pulses = 0; first_c = -1; gap = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_double = 1'b0; req_addr = 32'h0000_07FF;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 0) begin
        chk("b2b_first_addr", mem_address, 32'h0000_07FF);
        req_addr = 32'h0000_0100;
      end
      if (c == 1) begin
        chk("b2b_busy_ready", {31'b0, req_ready}, 32'd0);
        req_addr = 32'h0000_0008;
      end
      if (c == 3) begin
        chk("b2b_second_addr", mem_address, 32'h0000_0008);
        req_valid = 1'b0;
      end
      if (resp_valid) begin
        pulses++;
        if (first_c < 0) begin
          first_c = c;
          chk("b2b_rdata0", resp_rdata, 32'h0000_A5A5);
        end else begin
          gap = c - first_c;
          chk("b2b_rdata1", resp_rdata, 32'h0000_0DDF);
        end
      end
    end
    chk("b2b_pulses", pulses, 32'd2);
    chk("b2b_gap", gap, 32'd3);

    // Reset during SECOND of a double store to 0x20.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_double = 1'b1;
    req_addr = 32'h0000_0020; req_wdata = 32'h1111_2222;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_second_addr", mem_address, 32'h0000_0021);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_mid_stall", {31'b0, stall}, 32'd0);
    chk("rst_mid_resp", {31'b0, resp_valid}, 32'd0);
    chk("rst_mid_rdata", resp_rdata, 32'd0);
    chk("rst_mid_memctl", {30'b0, mem_read, mem_write}, 32'd0);
    chk("rst_mid_addr", mem_address, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    chk("rst_mid_no_resp", pulses, 32'd0);
    chk("rst_mid_ready_after", {31'b0, req_ready}, 32'd1);
    chk("rst_mid_mem20", {16'b0, mem[12'h020]}, 32'h0000_1111);
    chk("rst_mid_mem21", {16'b0, mem[12'h021]}, 32'h0000_BEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
